// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple slice per stage,
// carry registered between slices, valid/ready stream with whole-pipe stall.
module addsub_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned STAGES   = WIDTH / CHUNK;
    // Stage k forwards only the operand bits above its own slice; the fields
    // are packed back to back so every forwarded bit is consumed downstream.
    localparam int unsigned FWD_BITS = (STAGES > 1) ?
        ((STAGES - 1) * WIDTH - CHUNK * (STAGES - 1) * STAGES / 2) : 1;
    localparam int unsigned FWD_N    = (STAGES > 1) ? STAGES - 1 : 1;

    logic                          w_en;
    logic [WIDTH-1:0]              w_b_eff;
    logic                          w_cin_eff;
    logic [FWD_BITS-1:0]           w_a_fwd;
    logic [FWD_BITS-1:0]           w_b_fwd;
    logic [FWD_N-1:0]              w_c_fwd;
    logic [FWD_N-1:0]              w_mode_fwd;
    logic [STAGES-1:0]             w_vld_q;
    logic [STAGES-1:0][WIDTH-1:0]  w_res_q;

    assign out_valid = w_vld_q[STAGES-1];
    assign result    = w_res_q[STAGES-1];
    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en;

    // Subtraction as a + ~b + !cin, so a set carry-out means no borrow.
    assign w_b_eff   = mode ? ~b : b;
    assign w_cin_eff = mode ? ~cin : cin;

    if (STAGES == 1) begin : g_no_fwd
        assign w_a_fwd    = '0;
        assign w_b_fwd    = '0;
        assign w_c_fwd    = '0;
        assign w_mode_fwd = '0;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * CHUNK;

        logic [CHUNK-1:0] w_a_sl;
        logic [CHUNK-1:0] w_b_sl;
        logic             w_cin_sl;
        logic             w_mode_sl;
        logic             w_vld_sl;
        logic [WIDTH-1:0] w_res_in;
        logic [WIDTH-1:0] w_res_out;
        logic [CHUNK:0]   w_sum;
        logic             r_vld;
        logic [WIDTH-1:0] r_res;

        if (k == 0) begin : g_src_in
            assign w_a_sl    = a[CHUNK-1:0];
            assign w_b_sl    = w_b_eff[CHUNK-1:0];
            assign w_cin_sl  = w_cin_eff;
            assign w_mode_sl = mode;
            assign w_vld_sl  = in_valid;
            assign w_res_in  = '0;
        end else begin : g_src_pipe
            localparam int unsigned POFF = (k - 1) * WIDTH - CHUNK * (k - 1) * k / 2;
            assign w_a_sl    = w_a_fwd[POFF +: CHUNK];
            assign w_b_sl    = w_b_fwd[POFF +: CHUNK];
            assign w_cin_sl  = w_c_fwd[k-1];
            assign w_mode_sl = w_mode_fwd[k-1];
            assign w_vld_sl  = w_vld_q[k-1];
            assign w_res_in  = w_res_q[k-1];
        end

        assign w_sum = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, w_cin_sl};

        always_comb begin
            w_res_out                = w_res_in;
            w_res_out[LO +: CHUNK]   = w_sum[CHUNK-1:0];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_res <= '0;
            end else if (w_en) begin
                r_vld <= w_vld_sl;
                r_res <= w_res_out;
            end
        end

        assign w_vld_q[k] = r_vld;
        assign w_res_q[k] = r_res;

        if (k < STAGES - 1) begin : g_fwd
            localparam int unsigned REM = WIDTH - (k + 1) * CHUNK;
            localparam int unsigned OFF = k * WIDTH - CHUNK * k * (k + 1) / 2;

            logic [REM-1:0] w_a_hi;
            logic [REM-1:0] w_b_hi;
            logic [REM-1:0] r_a_hi;
            logic [REM-1:0] r_b_hi;
            logic           r_c;
            logic           r_mode;

            if (k == 0) begin : g_hi_in
                assign w_a_hi = a[WIDTH-1:CHUNK];
                assign w_b_hi = w_b_eff[WIDTH-1:CHUNK];
            end else begin : g_hi_pipe
                localparam int unsigned POFF = (k - 1) * WIDTH - CHUNK * (k - 1) * k / 2;
                assign w_a_hi = w_a_fwd[POFF + CHUNK +: REM];
                assign w_b_hi = w_b_fwd[POFF + CHUNK +: REM];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                    r_c    <= 1'b0;
                    r_mode <= 1'b0;
                end else if (w_en) begin
                    r_a_hi <= w_a_hi;
                    r_b_hi <= w_b_hi;
                    r_c    <= w_sum[CHUNK];
                    r_mode <= w_mode_sl;
                end
            end

            assign w_a_fwd[OFF +: REM] = r_a_hi;
            assign w_b_fwd[OFF +: REM] = r_b_hi;
            assign w_c_fwd[k]          = r_c;
            assign w_mode_fwd[k]       = r_mode;
        end else begin : g_last
            logic w_cout_nxt;
            logic w_ovf_nxt;
            logic w_zero_nxt;
            logic r_cout;
            logic r_ovf;
            logic r_zero;

            // Top slice holds both operand MSBs, so overflow needs no extra state.
            assign w_cout_nxt = w_sum[CHUNK] ^ w_mode_sl;
            assign w_ovf_nxt  = (w_a_sl[CHUNK-1] == w_b_sl[CHUNK-1]) &&
                                (w_sum[CHUNK-1] != w_a_sl[CHUNK-1]);
            assign w_zero_nxt = (w_res_out == '0);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_en) begin
                    r_cout <= w_vld_sl && w_cout_nxt;
                    r_ovf  <= w_vld_sl && w_ovf_nxt;
                    r_zero <= w_vld_sl && w_zero_nxt;
                end
            end

            assign cout = r_cout;
            assign ovf  = r_ovf;
            assign zero = r_zero;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (WIDTH=8, CHUNK=4): expected results are
// queued on accept and compared when the output handshake completes.
module tb_addsub_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       cout;
    logic       ovf;
    logic       zero;

    addsub_pipe #(.WIDTH(8), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] res;
        logic       co;
        logic       ov;
        logic       z;
    } exp_t;

    exp_t        q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned n_out   = 0;
    logic        held_v  = 1'b0;
    exp_t        held;

    logic [7:0] da [6] = '{8'h3C, 8'h00, 8'h80, 8'hFF, 8'h7F, 8'h0F};
    logic [7:0] db [6] = '{8'h05, 8'h01, 8'h01, 8'h01, 8'h01, 8'h0F};
    logic       dm [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic m, input logic c);
        exp_t       e;
        logic [8:0] u;
        int         sx;
        int         sy;
        int         s;
        sx = $signed(x);
        sy = $signed(y);
        if (!m) begin
            u = {1'b0, x} + {1'b0, y} + {8'd0, c};
            s = sx + sy + (c ? 1 : 0);
        end else begin
            u = {1'b0, x} - {1'b0, y} - {8'd0, c};
            s = sx - sy - (c ? 1 : 0);
        end
        e.res = u[7:0];
        e.co  = u[8];
        e.ov  = (s > 127) || (s < -128);
        e.z   = (u[7:0] == 8'h00);
        return e;
    endfunction

    // One bus cycle: drive at negedge, observe 1 time unit later, before the next posedge.
    task automatic cycle(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                         input logic m, input logic ic, input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        a         = ia;
        b         = ib;
        mode      = m;
        cin       = ic;
        out_ready = ordy;
        #1;
        if (held_v) begin
            check("hold_result", result, held.res);
            check("hold_flags", {cout, ovf, zero}, {held.co, held.ov, held.z});
        end
        held_v = out_valid && !out_ready;
        held   = {result, cout, ovf, zero};
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                check("result", result, e.res);
                check("cout", cout, e.co);
                check("ovf", ovf, e.ov);
                check("zero", zero, e.z);
                n_out++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(ia, ib, m, ic));
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && q.size() != 0; i++)
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int unsigned n0;

        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; cin = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_result", result, 8'h00);
        check("rst_flags", {cout, ovf, zero}, 3'b000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed single ops with a latency check on each.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, da[i], db[i], dm[i], 1'b0, 1'b1, acc);
            check("dir_accept", acc, 1'b1);
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, acc);
            check("dir_lat1_valid", out_valid, 1'b0);
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, acc);
            check("dir_lat2_valid", out_valid, 1'b1);
            drain();
        end

        // Carry/borrow-in corners.
        cycle(1'b1, 8'hFE, 8'h01, 1'b0, 1'b1, 1'b1, acc);
        cycle(1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, acc);
        cycle(1'b1, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1, acc);
        drain();

        // Back-to-back stream: outputs must occupy exactly cycles 2..7.
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                cycle(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
                check("b2b_accept", acc, 1'b1);
            end else begin
                cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, acc);
            end
            check("b2b_valid", out_valid, (i >= 2 && i < 8) ? 1'b1 : 1'b0);
        end
        drain();

        // Back-pressure: fill the pipe, hold 3 cycles, then release.
        n0 = n_out;
        cycle(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, acc);
        check("fill0_accept", acc, 1'b1);
        cycle(1'b1, 8'h9A, 8'hBC, 1'b1, 1'b1, 1'b0, acc);
        check("fill1_accept", acc, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, acc);
            check("stall_in_ready", acc, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
        end
        cycle(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1, acc);
        check("release_accept", acc, 1'b1);
        drain();
        check("stall_drain_count", n_out - n0, 3);

        // Reset with two ops in flight.
        cycle(1'b1, 8'h55, 8'h11, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h66, 8'h22, 1'b1, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("prerst_out_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_result", result, 8'h00);
        q.delete();
        held_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, acc);
            check("postrst_out_valid", out_valid, 1'b0);
        end
        cycle(1'b1, 8'hC3, 8'h3C, 1'b1, 1'b0, 1'b1, acc);
        check("postrst_accept", acc, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
